// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - execute-stage HI/LO unit: single-cycle multiply, iterative restoring divide
// Owns architectural HI/LO; stalls the pipeline while a divide iterates.
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] srca_i,
  input  logic [WIDTH-1:0] srcb_i,
  input  logic             cancel_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam int         CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic             r_busy;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvs;
  logic             r_neg_q, r_neg_r, r_dvz;

  logic             w_issue, w_is_div, w_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH:0]   w_shift, w_diff;
  logic [WIDTH-1:0] w_rem_nxt, w_quo_nxt, w_q_fix, w_r_fix;
  logic [2*WIDTH-1:0] w_sprod, w_uprod;

  assign w_issue  = (r_state == S_IDLE) && start_i && !cancel_i;
  assign w_is_div = (op_i == OP_DIV) || (op_i == OP_DIVU);
  assign w_signed = (op_i == OP_DIV);
  assign w_a_neg  = w_signed && srca_i[WIDTH-1];
  assign w_b_neg  = w_signed && srcb_i[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -srca_i : srca_i;
  assign w_b_mag  = w_b_neg ? -srcb_i : srcb_i;

  assign w_sprod = {{WIDTH{srca_i[WIDTH-1]}}, srca_i} * {{WIDTH{srcb_i[WIDTH-1]}}, srcb_i};
  assign w_uprod = {{WIDTH{1'b0}}, srca_i} * {{WIDTH{1'b0}}, srcb_i};

  // r_quo starts as the dividend and shifts out its MSB while quotient bits shift in.
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_dvs};
  assign w_rem_nxt = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
  assign w_q_fix   = r_neg_q ? -w_quo_nxt : w_quo_nxt;
  assign w_r_fix   = r_neg_r ? -w_rem_nxt : w_rem_nxt;

  always_comb begin
    w_state_nxt = r_state;
    stall_o     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_issue && w_is_div) begin
          w_state_nxt = S_DIV;
          stall_o     = 1'b1;
        end
      end
      S_DIV: begin
        if (cancel_i) begin
          w_state_nxt = S_IDLE;
        end else begin
          stall_o = 1'b1;
          if (r_cnt == LAST) w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dvz   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_DIV);
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            case (op_i)
              OP_MULT:  {r_hi, r_lo} <= w_sprod;
              OP_MULTU: {r_hi, r_lo} <= w_uprod;
              OP_MTHI:  r_hi <= srca_i;
              OP_MTLO:  r_lo <= srca_i;
              OP_DIV, OP_DIVU: begin
                r_quo   <= w_a_mag;
                r_dvs   <= w_b_mag;
                r_rem   <= '0;
                r_cnt   <= '0;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
                r_dvz   <= (srcb_i == '0);
              end
              default: ;
            endcase
          end
        end
        S_DIV: begin
          if (!cancel_i) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + CW'(1);
            // Divide by zero runs the full latency but never commits.
            if (r_cnt == LAST && !r_dvz) begin
              r_lo <= w_q_fix;
              r_hi <= w_r_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o = r_busy;
  assign hi_o   = r_hi;
  assign lo_o   = r_lo;

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Execute-stage HI/LO unit. It consumes the hilowrite-class instructions produced by the main decoder: MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- It owns the architectural HI and LO registers and supplies them to MFHI/MFLO.
- Multiplies complete in one cycle.
- Divides use an iterative radix-2 restoring divider. The unit stalls the pipeline through `stall_o` until the quotient and remainder are written.

Parameters:
WIDTH, 32, operand and HI/LO width; divide iteration count equals WIDTH

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
start_i  in  1  a valid HI/LO instruction is in E this cycle
op_i  in  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none)
srca_i  in  WIDTH  rs operand after forwarding (dividend / multiplicand / MTHI-MTLO data)
srcb_i  in  WIDTH  rt operand after forwarding (divisor / multiplier)
cancel_i  in  1  E-stage flush (exception or redirect)
stall_o  out  1  hold F/D/E; combinational from state and inputs
busy_o  out  1  divider iterating (registered)
hi_o  out  WIDTH  current HI register
lo_o  out  WIDTH  current LO register

Behaviour:
- Reset (`rst` low, any time, including mid-division):
  - `hi_o`=0, `lo_o`=0.
  - State IDLE, `busy_o`=0, `stall_o`=0.
  - Iteration counter and partial remainder cleared.
- States: IDLE, DIV, DONE.
- IDLE with `start_i`=1 and `cancel_i`=0:
  - MULT: {HI,LO} <= signed 2·WIDTH-bit product at the next edge. No stall.
  - MULTU: unsigned product, same timing as MULT.
  - MTHI: HI <= `srca_i`. LO unchanged.
  - MTLO: LO <= `srca_i`. HI unchanged.
  - DIV/DIVU:
    - `stall_o`=1 in the same cycle.
    - Operands are latched. For DIV, magnitudes and sign flags are latched.
    - Next state is DIV with counter=0.
- IDLE with `cancel_i`=1: no operation; HI/LO unchanged; `stall_o`=0.
- DIV state:
  - One quotient bit per cycle, MSB first.
  - `busy_o`=1 and `stall_o`=1 throughout.
  - After WIDTH iterations the state moves to DONE.
  - On that transition edge: LO <= quotient, HI <= remainder.
  - Total `stall_o` high time is exactly WIDTH+1 cycles, counting the start cycle.
- DONE, exactly one cycle:
  - `stall_o`=0 and `busy_o`=0; the held instruction leaves E at the end of this cycle.
  - `start_i` is ignored, which prevents re-issuing the same divide.
  - Next state is IDLE.
- Signed fixup for DIV:
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wrap, no trap).
- Divide by zero (`srcb_i`=0): full WIDTH+1 stall latency, HI and LO left unchanged.
- `cancel_i`=1 in DIV:
  - Next state IDLE; HI/LO unchanged.
  - `stall_o` goes to 0 in the same cycle as `cancel_i`.
  - Partial results are discarded.
- `start_i` in DIV is ignored; no new operation is accepted until IDLE.
- `cancel_i` in DONE has no effect, because HI/LO are already committed.
- Op codes 0 and 7: no effect in any state.
- `hi_o`/`lo_o` always show the registered values; there is no internal bypass. MFHI immediately after MTHI is handled by the forwarding unit.

Test Plan:
- Reset then idle → `hi_o`=0, `lo_o`=0, `stall_o`=0, `busy_o`=0. Assert `rst` low for 3 cycles mid-DIV → same values immediately, asynchronously.
- MULT 0xFFFFFFFF × 0x00000002 → next cycle HI=0xFFFFFFFF, LO=0xFFFFFFFE, no stall. MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIVU 100 / 7 with `start_i` held until `stall_o` drops → `stall_o` high exactly 33 cycles, then LO=0x0000000E, HI=0x00000002. No second divide starts in the DONE cycle.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. DIVU 5 / 0 → 33 stall cycles, HI/LO unchanged.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 back-to-back → HI=0x12345678, LO=0x9ABCDEF0. MTHI with `cancel_i`=1 → HI unchanged.
- DIVU started, `cancel_i` pulsed at iteration 10 → `stall_o`=0 in the cancel cycle, state IDLE, HI/LO keep their pre-divide values. A MULT issued the next cycle completes normally.
